// File: rtl/mrd_rd_addr_gen_if.sv
// Read-beat bus from the address generator to the RAM read port / butterfly input.
// valid/ready: a beat transfers on a clock edge where out_valid && out_ready; once
// out_valid is high, every out_* field holds stable until that transfer happens.
interface mrd_rd_addr_gen_if #(
   parameter int AW  = 12,
   parameter int NFW = 3
);
   logic           out_valid;
   logic           out_ready;
   logic [AW-1:0]  out_addr;
   logic [NFW-1:0] out_m;
   logic [AW-1:0]  out_k;
   logic           out_sop;
   logic           out_eop;
   logic [2:0]     out_stage;

   modport master (
      output out_valid, out_addr, out_m, out_k, out_sop, out_eop, out_stage,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_addr, out_m, out_k, out_sop, out_eop, out_stage,
      output out_ready
   );
endinterface

// File: rtl/mrd_rd_addr_gen.sv
// Walks every radix-nf butterfly group of one DFT stage and issues RAM read
// addresses addr = k + m*stride (m inner, k outer), one per handshaked beat.
module mrd_rd_addr_gen #(
   parameter int AW  = 12,
   parameter int NFW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           stage,
   input  logic [NFW-1:0]       nf,
   input  logic [AW-1:0]        stride,
   mrd_rd_addr_gen_if.master    rd,
   output logic                 rd_ongoing,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [NFW-1:0] NF_MIN = NFW'(2);
   localparam logic [NFW-1:0] NF_MAX = NFW'(5);
   localparam logic [NFW-1:0] NF_ONE = NFW'(1);
   localparam logic [AW-1:0]  A_ONE  = AW'(1);

   state_t         state_q, state_d;
   logic [NFW-1:0] nf_q, nf_d, m_q, m_d;
   logic [AW-1:0]  stride_q, stride_d, k_q, k_d, addr_q, addr_d;
   logic [2:0]     stage_q, stage_d;
   logic           err_q, err_d;
   logic           params_ok, fire, last_m, last_k;

   assign params_ok = (nf >= NF_MIN) && (nf <= NF_MAX) && (stride != '0);
   assign fire      = (state_q == RUN) && rd.out_ready;
   assign last_m    = (m_q == nf_q - NF_ONE);
   assign last_k    = (k_q == stride_q - A_ONE);

   always_comb begin
      state_d  = state_q;
      nf_d     = nf_q;
      stride_d = stride_q;
      stage_d  = stage_q;
      m_d      = m_q;
      k_d      = k_q;
      addr_d   = addr_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (params_ok) begin
                  state_d  = RUN;
                  nf_d     = nf;
                  stride_d = stride;
                  stage_d  = stage;
                  m_d      = '0;
                  k_d      = '0;
                  addr_d   = '0;
               end else begin
                  // Rejected start: report through done/err, keep previous capture.
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            if (fire) begin
               if (last_m && last_k) begin
                  state_d = DONE;
               end else if (last_m) begin
                  m_d    = '0;
                  k_d    = k_q + A_ONE;
                  addr_d = k_q + A_ONE;
               end else begin
                  // Next input of the same group sits one stride further on.
                  m_d    = m_q + NF_ONE;
                  addr_d = addr_q + stride_q;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         nf_q     <= '0;
         stride_q <= '0;
         stage_q  <= '0;
         m_q      <= '0;
         k_q      <= '0;
         addr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         nf_q     <= nf_d;
         stride_q <= stride_d;
         stage_q  <= stage_d;
         m_q      <= m_d;
         k_q      <= k_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
      end
   end

   assign rd.out_valid = (state_q == RUN);
   assign rd.out_addr  = addr_q;
   assign rd.out_m     = m_q;
   assign rd.out_k     = k_q;
   assign rd.out_sop   = (state_q == RUN) && (m_q == '0);
   assign rd.out_eop   = (state_q == RUN) && last_m;
   assign rd.out_stage = stage_q;
   assign rd_ongoing   = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign err          = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mrd_rd_addr_gen.sv
// Randomized bench for mrd_rd_addr_gen: expected beat lists come from nested
// k/m loops over addr = k + m*stride, compared against handshaked beats.
module tb_mrd_rd_addr_gen;
   localparam int AW  = 12;
   localparam int NFW = 3;
   localparam int W   = 3 + 2 + NFW + 2 * AW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [2:0]     stage;
   logic [NFW-1:0] nf;
   logic [AW-1:0]  stride;
   logic           rd_ongoing, done, err;
   logic [1:0]     dbg_state;

   mrd_rd_addr_gen_if #(.AW(AW), .NFW(NFW)) bus ();

   mrd_rd_addr_gen #(.AW(AW), .NFW(NFW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .nf(nf),
      .stride(stride), .rd(bus), .rd_ongoing(rd_ongoing), .done(done),
      .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   // results of the last collect() call
   int           done_cyc, last_hs, rdo_bad, stall_bad, asrt_bad, cur_stride;
   logic         err_at_done, valid_at_done, rdo_at_done, done_after, err_after;
   logic [W+3:0] post_rst_word;

   function automatic logic [W-1:0] cur_word();
      return {bus.out_stage, bus.out_sop, bus.out_eop, bus.out_m, bus.out_k, bus.out_addr};
   endfunction

   // Reference: m inner loop, k outer loop, address k + m*stride.
   task automatic build_exp(input int n, input int s, input int st);
      logic [2:0] st_v; logic [NFW-1:0] m_v; logic [AW-1:0] k_v, a_v; logic sop, eop;
      exp_q.delete();
      for (int k = 0; k < s; k++)
         for (int m = 0; m < n; m++) begin
            st_v = 3'(st); m_v = NFW'(m); k_v = AW'(k); a_v = AW'(k + m * s);
            sop = (m == 0); eop = (m == n - 1);
            exp_q.push_back({st_v, sop, eop, m_v, k_v, a_v});
         end
   endtask

   function automatic int beat_mismatches();
      int bad = 0;
      if (obs_q.size() != exp_q.size()) return -1;
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
      return bad;
   endfunction

   always @(negedge clk)
      if (rst_n === 1'b1 && bus.out_valid === 1'b1)
         if (int'(bus.out_addr) != int'(bus.out_k) + int'(bus.out_m) * cur_stride) asrt_bad++;

   task automatic do_start(input int n, input int s, input int st);
      start = 1'b1; nf = NFW'(n); stride = AW'(s); stage = 3'(st); cur_stride = s;
      @(negedge clk);
      start = 1'b0;
      nf = NFW'($urandom); stride = AW'($urandom); stage = 3'($urandom);
   endtask

   // inj_kind 1: second start (nf=2) at beat inj_beat; 2: reset at beat inj_beat
   task automatic collect(input int ready_pct, input int max_cyc, input int inj_beat, input int inj_kind);
      logic [W-1:0] prev_word = '0;
      bit prev_stall = 0, injected = 0;
      obs_q.delete();
      done_cyc = -1; last_hs = -1; rdo_bad = 0; stall_bad = 0;
      err_at_done = 1'bx; valid_at_done = 1'bx; rdo_at_done = 1'bx;
      done_after = 1'bx; err_after = 1'bx; post_rst_word = '1;
      for (int c = 0; c < max_cyc; c++) begin
         start = 1'b0;
         if (inj_kind == 1 && !injected && obs_q.size() == inj_beat) begin
            start = 1'b1; nf = NFW'(2); stride = AW'(7); stage = 3'd1; injected = 1;
         end
         if (inj_kind == 2 && obs_q.size() == inj_beat) begin
            rst_n = 1'b0;
            @(negedge clk);
            post_rst_word = {cur_word(), bus.out_valid, rd_ongoing, done, err};
            rst_n = 1'b1;
            return;
         end
         bus.out_ready = ($urandom_range(0, 99) < ready_pct);
         if (prev_stall && cur_word() !== prev_word) stall_bad++;
         if (rd_ongoing !== bus.out_valid) rdo_bad++;
         if (done === 1'b1) begin
            done_cyc = c; err_at_done = err; valid_at_done = bus.out_valid; rdo_at_done = rd_ongoing;
            @(negedge clk);
            done_after = done; err_after = err;
            return;
         end
         if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back(cur_word());
            last_hs = c;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_word  = cur_word();
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; nf = '0; stride = '0; stage = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cur_word(), bus.out_valid, rd_ongoing, done, err} !== '0)
         $display("FAIL reset_outputs got=%h exp=0", {cur_word(), bus.out_valid, rd_ongoing, done, err});
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_rate();
      int bad;
      build_exp(4, 300, 0); asrt_bad = 0;
      do_start(4, 300, 0);
      collect(100, 3000, 0, 0);
      bad = beat_mismatches();
      checks++; if (bad != 0) $display("FAIL full_beats mismatches=%0d n=%0d exp_n=%0d", bad, obs_q.size(), exp_q.size()); else passes++;
      checks++; if (done_cyc != 1200) $display("FAIL full_done_cycle got=%0d exp=1200", done_cyc); else passes++;
      checks++; if (last_hs != 1199) $display("FAIL full_last_hs got=%0d exp=1199", last_hs); else passes++;
      checks++; if (err_at_done !== 1'b0 || valid_at_done !== 1'b0) $display("FAIL full_err_valid err=%b valid=%b exp=0,0", err_at_done, valid_at_done); else passes++;
      checks++; if (done_after !== 1'b0) $display("FAIL full_done_single got=%b exp=0", done_after); else passes++;
      checks++; if (rdo_bad != 0 || asrt_bad != 0) $display("FAIL full_rdo_addr rdo_bad=%0d asrt_bad=%0d exp=0", rdo_bad, asrt_bad); else passes++;
   endtask

   task automatic test_stall();
      int bad, st;
      logic [AW-1:0] a0, a4;
      st = $urandom_range(0, 7);
      build_exp(5, 240, st); asrt_bad = 0;
      do_start(5, 240, st);
      collect(50, 8000, 0, 0);
      bad = beat_mismatches();
      checks++; if (bad != 0) $display("FAIL stall_beats mismatches=%0d n=%0d exp_n=%0d", bad, obs_q.size(), exp_q.size()); else passes++;
      a0 = (obs_q.size() > 4) ? obs_q[0][AW-1:0] : '1;
      a4 = (obs_q.size() > 4) ? obs_q[4][AW-1:0] : '1;
      checks++; if (a0 !== 12'd0 || a4 !== 12'd960) $display("FAIL stall_first_group got=%0d,%0d exp=0,960", a0, a4); else passes++;
      checks++; if (stall_bad != 0) $display("FAIL stall_hold got=%0d changes exp=0", stall_bad); else passes++;
      checks++; if (rdo_bad != 0 || rdo_at_done !== 1'b0 || done_cyc != last_hs + 1)
         $display("FAIL stall_rdo_done rdo_bad=%0d rdo_at_done=%b done_cyc=%0d last_hs=%0d", rdo_bad, rdo_at_done, done_cyc, last_hs);
      else passes++;
   endtask

   task automatic test_stage_echo();
      int bad, n;
      logic [AW-1:0] l0, l1, l2;
      build_exp(3, 400, 4); asrt_bad = 0;
      do_start(3, 400, 4);
      collect(80, 4000, 0, 0);
      bad = beat_mismatches();
      n = obs_q.size();
      checks++; if (bad != 0) $display("FAIL stage_beats mismatches=%0d n=%0d exp_n=%0d", bad, n, exp_q.size()); else passes++;
      l0 = (n >= 3) ? obs_q[n-3][AW-1:0] : '0;
      l1 = (n >= 3) ? obs_q[n-2][AW-1:0] : '0;
      l2 = (n >= 3) ? obs_q[n-1][AW-1:0] : '0;
      checks++; if ({l0, l1, l2} !== {12'd399, 12'd799, 12'd1199}) $display("FAIL stage_last_addrs got=%0d,%0d,%0d exp=399,799,1199", l0, l1, l2); else passes++;
      checks++; if (asrt_bad != 0) $display("FAIL stage_addr_assert got=%0d bad exp=0", asrt_bad); else passes++;
      checks++; if (bus.out_stage !== 3'd4) $display("FAIL stage_hold_after got=%0d exp=4", bus.out_stage); else passes++;
   endtask

   task automatic test_illegal();
      int nfs[3] = '{1, 4, 0};
      int strs[3] = '{1200, 0, 100};
      for (int i = 0; i < 3; i++) begin
         do_start(nfs[i], strs[i], 2);
         collect(100, 50, 0, 0);
         checks++;
         if (obs_q.size() != 0 || done_cyc != 0 || err_at_done !== 1'b1 || valid_at_done !== 1'b0 || rdo_bad != 0)
            $display("FAIL illegal_%0d beats=%0d done_cyc=%0d err=%b valid=%b rdo_bad=%0d exp=0,0,1,0,0",
                     i, obs_q.size(), done_cyc, err_at_done, valid_at_done, rdo_bad);
         else passes++;
         checks++;
         if (done_after !== 1'b0 || err_after !== 1'b0 || bus.out_stage !== 3'd4)
            $display("FAIL illegal_pulse_%0d done=%b err=%b stage=%0d exp=0,0,4", i, done_after, err_after, bus.out_stage);
         else passes++;
      end
   endtask

   task automatic test_restart_ignored();
      int bad;
      build_exp(4, 300, 3);
      do_start(4, 300, 3);
      collect(100, 3000, 10, 1);
      bad = beat_mismatches();
      checks++; if (bad != 0) $display("FAIL restart_beats mismatches=%0d n=%0d exp_n=1200", bad, obs_q.size()); else passes++;
      checks++; if (done_cyc != 1200) $display("FAIL restart_done_cycle got=%0d exp=1200", done_cyc); else passes++;
   endtask

   task automatic test_reset_mid();
      int bad;
      build_exp(4, 300, 6);
      do_start(4, 300, 6);
      collect(100, 3000, 500, 2);
      checks++; if (post_rst_word !== '0) $display("FAIL midreset_outputs got=%h exp=0", post_rst_word); else passes++;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("FAIL midreset_no_done got=%b exp=0", done); else passes++;
      do_start(4, 300, 6);
      collect(70, 6000, 0, 0);
      bad = beat_mismatches();
      checks++; if (bad != 0) $display("FAIL midreset_replay mismatches=%0d n=%0d exp_n=1200", bad, obs_q.size()); else passes++;
   endtask

   task automatic test_random();
      int n, s, st, bad;
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(2, 5); s = $urandom_range(1, 60); st = $urandom_range(0, 7);
         build_exp(n, s, st); asrt_bad = 0;
         do_start(n, s, st);
         collect($urandom_range(30, 100), 2000, 0, 0);
         bad = beat_mismatches();
         checks++;
         if (bad != 0 || stall_bad != 0 || asrt_bad != 0 || done_cyc != last_hs + 1 || err_at_done !== 1'b0)
            $display("FAIL random_%0d nf=%0d stride=%0d mism=%0d stall=%0d asrt=%0d done_cyc=%0d last_hs=%0d err=%b",
                     it, n, s, bad, stall_bad, asrt_bad, done_cyc, last_hs, err_at_done);
         else passes++;
      end
   endtask

   initial begin
      cur_stride = 1;
      asrt_bad = 0;
      test_reset();
      test_full_rate();
      test_stall();
      test_stage_echo();
      test_illegal();
      test_restart_ignored();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mrd_rd_addr_gen.md
Name: mrd_rd_addr_gen

Overview:
- Memory-side consumer of the per-stage parameters produced by the top control FSM: the Nf, dftpts_div_Nf and current-stage values.
- For one DFT stage, walks every radix-Nf butterfly group and emits RAM read addresses, one per beat, with valid/ready backpressure.
- Drives the rd_ongoing status back to the control FSM, and a done pulse when the stage is finished.
- Sits inside the mem top, between the control interface and the RAM read port and butterfly input.

Parameters:
- AW, 12, address / point-count width (max DFT size 4095).
- NFW, 3, radix field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: begin read pass for the stage described by the inputs below
- stage  in  3  current stage index; captured at start, echoed on out_stage
- nf  in  NFW  radix of this stage; legal values 2,3,4,5
- stride  in  AW  dftpts/nf for this stage (dftpts_div_Nf)
- out_ready  in  1  downstream accepts a beat
- out_valid  out  1  beat valid
- out_addr  out  AW  RAM read address
- out_m  out  NFW  butterfly input index, 0..nf-1
- out_k  out  AW  butterfly group index, 0..stride-1
- out_sop  out  1  high on m==0 beat of each group
- out_eop  out  1  high on m==nf-1 beat of each group
- out_stage  out  3  captured stage
- rd_ongoing  out  1  high from the cycle after start until the last beat handshakes
- done  out  1  one-cycle pulse, the cycle after the last handshake
- err  out  1  one-cycle pulse with done when the parameters are illegal

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- FSM states and transitions:
  - IDLE: wait for start.
  - RUN: emit beats.
  - DONE: 1 cycle, then IDLE.
- IDLE -> RUN on start with legal parameters:
  - Capture nf, stride and stage.
  - Set k=0, m=0, addr=0.
  - out_valid rises the next cycle (latency 1).
- IDLE -> DONE on start with illegal parameters: nf not in {2,3,4,5}, or stride==0.
  - No beats are emitted.
  - done=1 and err=1 in the cycle after start.
  - rd_ongoing stays 0.
- Beat sequence: addr = k + m*stride.
  - The address is computed incrementally with an adder only, no multiplier:
    - m advance: addr += stride.
    - group advance: addr = k+1, m=0.
  - Order: m is the inner loop, k the outer loop.
  - Total beats = nf*stride.
- Handshake: a beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - out_valid never drops before the last beat transfers.
  - No beat transfers in the cycle of start.
- Last beat: k==stride-1, m==nf-1.
  - On its handshake, next cycle: out_valid=0, rd_ongoing=0, done=1, state=DONE.
- Arithmetic: addr is AW bits with no wrap. stride*nf ≤ 4095 is a caller guarantee; overflow is not checked.
- start while in RUN or DONE: ignored; the captured parameters are unchanged.
- Changes on the nf, stride or stage inputs after start have no effect.
- Reset mid-operation: returns to IDLE next cycle; all outputs 0; no done pulse.
- out_stage: holds its captured value until the next accepted start.

Test Plan:
- nf=4, stride=300, stage=0, out_ready=1 -> 1200 beats, one per cycle.
  - Addresses 0,300,600,900,1,301,601,901,... ending 299,599,899,1199.
  - out_sop on m=0 beats and out_eop on m=3 beats.
  - done is a single pulse one cycle after the beat with address 1199; err=0.
- nf=5, stride=240, out_ready toggling on a random 50% pattern -> 1200 handshaked beats.
  - The first group is 0,240,480,720,960.
  - Outputs hold stable during every stall.
  - rd_ongoing falls exactly when done rises.
- nf=3, stride=400, stage=4 -> out_stage=4 throughout.
  - Last addresses are 399,799,1199.
  - An assertion holds on every beat: out_addr == out_k + out_m*stride.
- nf=1, stride=1200 -> no out_valid, done=err=1 one cycle after start. Repeat with nf=4, stride=0: same response.
- Second start pulse at beat 10 with nf=2 -> ignored; the sequence continues with nf=4 and still totals 1200 beats.
- rst_n=0 asserted at beat 500 -> next cycle all outputs are 0 with no done pulse; a fresh start then replays the sequence from address 0.
